// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scan counters, sync/active/marker decode and a
// frame number, with an optional enable-qualified output delay line.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int H_SIZE     = 10,
  parameter int V_SIZE     = 10,
  parameter int FRAME_W    = 8,
  parameter int PIPE_DLY   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fc_clear,
  input  logic               fc_enable,
  output logic [H_SIZE-1:0]  tg_hcount,
  output logic [V_SIZE-1:0]  tg_vcount,
  output logic               tg_hsync,
  output logic               tg_vsync,
  output logic               tg_display,
  output logic               tg_line_start,
  output logic               tg_frame_start,
  output logic               tg_frame_end,
  output logic               tg_vblank_start,
  output logic [FRAME_W-1:0] tg_frame_num
);

  localparam int H_COUNT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_COUNT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int BW      = H_SIZE + V_SIZE + FRAME_W + 7;

  localparam logic [H_SIZE-1:0] H_LAST   = H_SIZE'(H_COUNT - 1);
  localparam logic [H_SIZE-1:0] H_ACT    = H_SIZE'(H_DISPLAY);
  localparam logic [H_SIZE-1:0] HS_FIRST = H_SIZE'(H_DISPLAY + H_FRONT);
  localparam logic [H_SIZE-1:0] HS_LAST  = H_SIZE'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [V_SIZE-1:0] V_LAST   = V_SIZE'(V_COUNT - 1);
  localparam logic [V_SIZE-1:0] V_ACT    = V_SIZE'(V_DISPLAY);
  localparam logic [V_SIZE-1:0] VS_FIRST = V_SIZE'(V_DISPLAY + V_FRONT);
  localparam logic [V_SIZE-1:0] VS_LAST  = V_SIZE'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Idle bundle: counters zero, syncs at their inactive level, flags clear
  localparam logic [BW-1:0] BUNDLE_RST = {{H_SIZE{1'b0}}, {V_SIZE{1'b0}}, {FRAME_W{1'b0}},
                                          ~H_SYNC_POL, ~V_SYNC_POL, 5'b00000};

  if ((1 << H_SIZE) < H_COUNT) begin : g_err_hsize
    $error("H_SIZE too small for H_COUNT");
  end
  if ((1 << V_SIZE) < V_COUNT) begin : g_err_vsize
    $error("V_SIZE too small for V_COUNT");
  end
  if (H_DISPLAY <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0 ||
      V_DISPLAY <= 0 || V_FRONT <= 0 || V_SYNC <= 0 || V_BACK <= 0) begin : g_err_zero
    $error("timing parameters must be non-zero");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_err_pipe
    $error("PIPE_DLY must be in 0..4");
  end

  logic [H_SIZE-1:0]  r_h;
  logic [V_SIZE-1:0]  r_v;
  logic [FRAME_W-1:0] r_f;

  // Stage-0 scan counters and frame number
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= H_SIZE'(0);
      r_v <= V_SIZE'(0);
      r_f <= FRAME_W'(0);
    end else if (fc_clear) begin
      r_h <= H_SIZE'(0);
      r_v <= V_SIZE'(0);
      r_f <= FRAME_W'(0);
    end else if (fc_enable) begin
      if (r_h == H_LAST) begin
        r_h <= H_SIZE'(0);
        if (r_v == V_LAST) begin
          r_v <= V_SIZE'(0);
          r_f <= r_f + FRAME_W'(1);
        end else begin
          r_v <= r_v + V_SIZE'(1);
        end
      end else begin
        r_h <= r_h + H_SIZE'(1);
      end
    end
  end

  logic          w_hsync;
  logic          w_vsync;
  logic          w_display;
  logic          w_line_start;
  logic          w_frame_start;
  logic          w_frame_end;
  logic          w_vblank_start;
  logic [BW-1:0] w_stage0;
  logic [BW-1:0] w_out;

  assign w_hsync        = (r_h >= HS_FIRST && r_h <= HS_LAST) ? H_SYNC_POL : ~H_SYNC_POL;
  assign w_vsync        = (r_v >= VS_FIRST && r_v <= VS_LAST) ? V_SYNC_POL : ~V_SYNC_POL;
  assign w_display      = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_line_start   = (r_h == H_SIZE'(0));
  assign w_frame_start  = (r_h == H_SIZE'(0)) && (r_v == V_SIZE'(0));
  assign w_frame_end    = (r_h == H_LAST) && (r_v == V_LAST);
  assign w_vblank_start = (r_h == H_SIZE'(0)) && (r_v == V_ACT);

  assign w_stage0 = {r_h, r_v, r_f, w_hsync, w_vsync, w_display, w_line_start,
                     w_frame_start, w_frame_end, w_vblank_start};

  if (PIPE_DLY == 0) begin : g_nopipe
    assign w_out = w_stage0;
  end else begin : g_pipe
    logic [BW-1:0] r_pipe [PIPE_DLY];

    // Delay line shifts only on enabled cycles so every field stays aligned
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DLY; i++) r_pipe[i] <= BUNDLE_RST;
      end else if (fc_clear) begin
        for (int i = 0; i < PIPE_DLY; i++) r_pipe[i] <= BUNDLE_RST;
      end else if (fc_enable) begin
        r_pipe[0] <= w_stage0;
        for (int i = 1; i < PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign w_out = r_pipe[PIPE_DLY-1];
  end

  assign {tg_hcount, tg_vcount, tg_frame_num, tg_hsync, tg_vsync, tg_display,
          tg_line_start, tg_frame_start, tg_frame_end, tg_vblank_start} = w_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small raster (14x8), one undelayed and
// one 3-stage instance driven by the same controls.
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  logic fc_clear;
  logic fc_enable;

  logic [3:0] h0, h3;
  logic [2:0] v0, v3;
  logic [1:0] fn0, fn3;
  logic hs0, vs0, de0, ls0, fs0, fe0, vb0;
  logic hs3, vs3, de3, ls3, fs3, fe3, vb3;

  int n_total;
  int n_bad;
  int k;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .H_SIZE(4), .V_SIZE(3), .FRAME_W(2), .PIPE_DLY(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .fc_clear(fc_clear), .fc_enable(fc_enable),
    .tg_hcount(h0), .tg_vcount(v0), .tg_hsync(hs0), .tg_vsync(vs0),
    .tg_display(de0), .tg_line_start(ls0), .tg_frame_start(fs0),
    .tg_frame_end(fe0), .tg_vblank_start(vb0), .tg_frame_num(fn0)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .H_SIZE(4), .V_SIZE(3), .FRAME_W(2), .PIPE_DLY(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .fc_clear(fc_clear), .fc_enable(fc_enable),
    .tg_hcount(h3), .tg_vcount(v3), .tg_hsync(hs3), .tg_vsync(vs3),
    .tg_display(de3), .tg_line_start(ls3), .tg_frame_start(fs3),
    .tg_frame_end(fe3), .tg_vblank_start(vb3), .tg_frame_num(fn3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after n enabled edges since reset/clear; n < 0 = idle bundle
  task automatic check_pos(input string tag, input int n,
                           input logic [3:0] h, input logic [2:0] v, input logic [1:0] fn,
                           input logic hs, input logic vs, input logic de, input logic ls,
                           input logic fs, input logic fe, input logic vb);
    int p, eh, ev;
    if (n < 0) begin
      check({tag, ".h"}, h, 0);   check({tag, ".v"}, v, 0);   check({tag, ".fn"}, fn, 0);
      check({tag, ".hs"}, hs, 1); check({tag, ".vs"}, vs, 1); check({tag, ".de"}, de, 0);
      check({tag, ".ls"}, ls, 0); check({tag, ".fs"}, fs, 0); check({tag, ".fe"}, fe, 0);
      check({tag, ".vb"}, vb, 0);
    end else begin
      p  = n % 112;
      eh = p % 14;
      ev = p / 14;
      check({tag, ".h"}, h, eh);
      check({tag, ".v"}, v, ev);
      check({tag, ".fn"}, fn, (n / 112) % 4);
      check({tag, ".hs"}, hs, (eh >= 10 && eh <= 12) ? 0 : 1);
      check({tag, ".vs"}, vs, (ev == 5 || ev == 6) ? 0 : 1);
      check({tag, ".de"}, de, (eh < 8 && ev < 4) ? 1 : 0);
      check({tag, ".ls"}, ls, (eh == 0) ? 1 : 0);
      check({tag, ".fs"}, fs, (p == 0) ? 1 : 0);
      check({tag, ".fe"}, fe, (p == 111) ? 1 : 0);
      check({tag, ".vb"}, vb, (eh == 0 && ev == 4) ? 1 : 0);
    end
  endtask

  task automatic check_both(input int n);
    check_pos("d0", n, h0, v0, fn0, hs0, vs0, de0, ls0, fs0, fe0, vb0);
    check_pos("d3", n - 3, h3, v3, fn3, hs3, vs3, de3, ls3, fs3, fe3, vb3);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    k         = 0;
    rst       = 1'b1;
    fc_clear  = 1'b0;
    fc_enable = 1'b0;
    #2;
    check_both(0);
    @(negedge clk);
    rst       = 1'b0;
    fc_enable = 1'b1;

    // Continuous scan past four frames so the frame number wraps 3 -> 0
    for (int c = 0; c < 460; c++) begin
      tick();
      k++;
      check_both(k);
    end

    // Enable toggling: state advances only on edges where enable was high
    for (int c = 0; c < 40; c++) begin
      fc_enable = (c % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      if (fc_enable) k++;
      check_both(k);
    end

    // Move to h=5, v=2, then clear together with enable
    fc_enable = 1'b1;
    for (int c = 0; c < 120 && (k % 112) != 33; c++) begin
      tick();
      k++;
      check_both(k);
    end
    check("pre_clr.h", h0, 5);
    check("pre_clr.v", v0, 2);
    fc_clear = 1'b1;
    tick();
    fc_clear = 1'b0;
    k = 0;
    check_both(k);
    for (int c = 0; c < 20; c++) begin
      tick();
      k++;
      check_both(k);
    end

    // Asynchronous reset mid-frame, checked before any clock edge
    #1;
    rst = 1'b1;
    #1;
    check_both(0);
    check("async.h", h0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the vga_core video path. It runs the horizontal/vertical scan counters from one pixel-enable qualified clock and decodes hsync, vsync, display-active and frame/line markers from compile-time timing parameters. An optional output pipeline delays the whole timing bundle so it stays aligned with downstream pipelined pixel generators. It also maintains a free-running frame number.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level
- H_SIZE, 10, horizontal counter width
- V_SIZE, 10, vertical counter width
- FRAME_W, 8, frame number width
- PIPE_DLY, 0, output delay in enabled cycles, 0..4

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-high reset
- fc_clear  in  1  synchronous clear of counters, frame number and pipeline
- fc_enable  in  1  pixel enable; counters and pipeline advance only when high
- tg_hcount  out  H_SIZE  horizontal position
- tg_vcount  out  V_SIZE  vertical position
- tg_hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- tg_vsync  out  1  vertical sync, polarity per V_SYNC_POL
- tg_display  out  1  position inside the active area
- tg_line_start  out  1  hcount == 0
- tg_frame_start  out  1  hcount == 0 and vcount == 0
- tg_frame_end  out  1  last pixel of the frame
- tg_vblank_start  out  1  hcount == 0 and vcount == V_DISPLAY
- tg_frame_num  out  FRAME_W  frames completed since reset/clear, modulo 2^FRAME_W

## Operation
- H_COUNT = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_COUNT is the vertical equivalent.
- Elaboration error if 2^H_SIZE < H_COUNT, 2^V_SIZE < V_COUNT, any timing parameter is 0, or PIPE_DLY > 4.
- Stage-0 counters h, v and frame register f:
  - If fc_enable is high, h increments and wraps from H_COUNT-1 to 0.
  - v increments only on an enabled cycle where h == H_COUNT-1, and wraps from V_COUNT-1 to 0.
  - f increments, wrapping modulo 2^FRAME_W, on an enabled cycle where h == H_COUNT-1 and v == V_COUNT-1.
- Stage-0 decode:
  - display = (h < H_DISPLAY) & (v < V_DISPLAY)
  - hsync is active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]
  - vsync is active for v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], for entire lines
  - Inactive level is the inverse of the polarity parameter.
- Output bundle: stage-0 h, v, decodes and f.
  - PIPE_DLY = 0: outputs are combinational from stage 0.
  - PIPE_DLY = N: bundle passes through N register stages that shift only when fc_enable is high. All bundle fields stay mutually aligned.
- fc_clear (synchronous): counters, f and all pipeline stages go to reset values. fc_clear takes priority over fc_enable.
- rst (asynchronous): same values, applied immediately, including mid-line or mid-frame.

## Timing
- Reset values:
  - Counters and frame number: 0.
  - Pipeline stages: hcount 0, vcount 0, hsync/vsync inactive level, all other flags 0.
  - With PIPE_DLY = 0, outputs after reset reflect h = v = 0: tg_display = 1, tg_line_start = 1, tg_frame_start = 1.
- Latency: output = stage-0 state delayed by exactly PIPE_DLY enabled cycles.
- Stalls: fc_enable low freezes counters and all stages; outputs hold.
- Frame wrap:
  - tg_frame_end and the next tg_frame_start are on consecutive enabled output samples.
  - tg_frame_num increments on the same output sample as tg_frame_start.
- After clear with PIPE_DLY = N: the first N enabled output samples carry reset values, then h = 0, v = 0.

## Test plan
Common small parameters: H 8/2/3/1 (H_COUNT 14), V 4/1/2/1 (V_COUNT 8), active-low syncs, FRAME_W 2.
- PIPE_DLY 0, fc_enable held high, after rst:
  - hcount cycles 0..13.
  - tg_hsync low exactly at h = 10, 11, 12.
  - tg_display high at h = 0..7 for v = 0..3.
  - tg_vsync low for all of v = 5, 6.
- Frame wrap:
  - tg_frame_end at h = 13, v = 7 (cycle 111 after reset).
  - Next cycle: tg_frame_start, and tg_frame_num 0 -> 1.
  - After 4 frames tg_frame_num wraps 3 -> 0.
  - tg_vblank_start at h = 0, v = 4.
- fc_enable toggled 1/0 every cycle: counters advance every other cycle; all outputs hold on the low cycles.
- PIPE_DLY 3: every output equals the PIPE_DLY 0 reference delayed by 3 enabled cycles. First 3 samples after rst: hsync = 1, vsync = 1, display = 0.
- fc_clear at h = 5, v = 2, asserted together with fc_enable: next cycle h = v = 0, frame_num = 0. Also assert rst mid-frame: outputs are reset immediately, without waiting for a clock edge.
